// File: rtl/i2c_regbank_mc_pkg.sv
// Register-map constants and the SR readback packing for the multi-channel I2C register bank.
// Pure definitions: no latency and no flow control.
package i2c_regbank_mc_pkg;

  typedef enum logic [5:0] {
    REG_ADR   = 6'd0,
    REG_FDR   = 6'd1,
    REG_CR    = 6'd2,
    REG_SR    = 6'd3,
    REG_DR    = 6'd4,
    REG_DFSRR = 6'd5,
    REG_FSR   = 6'd6
  } reg_word_e;

  localparam int SR_MCF  = 7;
  localparam int SR_MBB  = 5;
  localparam int SR_MAL  = 4;
  localparam int SR_SRW  = 2;
  localparam int SR_MIF  = 1;
  localparam int SR_RXAK = 0;

  localparam int CR_MIEN = 6;

  localparam int FSR_TXOVF = 7;
  localparam int FSR_RXUNF = 6;
  localparam int FSR_RXOVF = 5;

  localparam logic [7:0] DFSRR_RST = 8'h10;

  // Live core bits merged with the two software-visible sticky bits.
  function automatic logic [7:0] sr_pack(input logic [7:0] core, input logic mal, input logic mif);
    return {core[SR_MCF], 1'b0, core[SR_MBB], mal, 1'b0, core[SR_SRW], mif, core[SR_RXAK]};
  endfunction

endpackage

// File: rtl/i2c_regbank_mc_if.sv
// Register-access strobe bus between the AXI-Lite front end and the register bank.
// Read data returns one cycle after the read strobe; there is no backpressure.
interface i2c_regbank_mc_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic                i2c_reg_wren;
  logic                i2c_reg_rden;
  logic [DATA_W-1:0]   i2c_reg_data;
  logic                i2c_reg_rvalid;

  modport master (
    output S_AXI_AWADDR, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_ARADDR, i2c_reg_wren, i2c_reg_rden,
    input  i2c_reg_data, i2c_reg_rvalid
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_ARADDR, i2c_reg_wren, i2c_reg_rden,
    output i2c_reg_data, i2c_reg_rvalid
  );
endinterface

// File: rtl/i2c_regbank_mc_byte_fifo.sv
// Synchronous 8-bit FIFO; head is visible combinationally, push/pop take effect on the clock edge.
// Push while full is dropped (o_drop) unless a pop frees a slot in the same cycle; pop while empty is ignored.
module i2c_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_arst_n,
  input  logic                     i_push,
  input  logic [7:0]               i_din,
  input  logic                     i_pop,
  output logic [7:0]               o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_drop,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0] r_mem [DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  logic w_pop, w_push;

  // Extra pointer MSB tells full from empty once the indices wrap.
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_drop  = i_push & ~w_push;
  assign o_dout  = r_mem[r_rptr[AW-1:0]];
  assign o_level = r_wptr - r_rptr;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_din;
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end
endmodule

// File: rtl/i2c_regbank_mc.sv
// NUM_CH banks of I2C registers with per-channel TX/RX byte FIFOs behind DR, sticky status and irq.
// Writes land on the strobe edge; read data/rvalid are registered one cycle after rden; no backpressure.
module i2c_regbank_mc
  import i2c_regbank_mc_pkg::*;
#(
  parameter int         C_S_AXI_DATA_WIDTH = 32,
  parameter int         C_S_AXI_ADDR_WIDTH = 12,
  parameter int         NUM_CH             = 4,
  parameter logic [3:0] BASE_PAGE          = 4'h1,
  parameter int         FIFO_DEPTH         = 8
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  i2c_regbank_mc_if.slave       bus,
  output logic [NUM_CH*8-1:0]   cfg_adr,
  output logic [NUM_CH*8-1:0]   cfg_fdr,
  output logic [NUM_CH*8-1:0]   cfg_cr,
  output logic [NUM_CH*8-1:0]   cfg_dfsrr,
  input  logic [NUM_CH*8-1:0]   core_status,
  input  logic [NUM_CH-1:0]     core_mif_set,
  input  logic [NUM_CH-1:0]     core_mal_set,
  output logic [NUM_CH*8-1:0]   core_tx_data,
  output logic [NUM_CH-1:0]     core_tx_valid,
  input  logic [NUM_CH-1:0]     core_tx_pop,
  input  logic [NUM_CH*8-1:0]   core_rx_data,
  input  logic [NUM_CH-1:0]     core_rx_push,
  output logic [NUM_CH-1:0]     irq
);
  localparam int         PAGE_LSB = C_S_AXI_ADDR_WIDTH - 4;
  localparam logic [4:0] NCH      = 5'(NUM_CH);
  localparam int         LW       = $clog2(FIFO_DEPTH) + 1;

  logic [3:0]                    w_wr_diff, w_rd_diff;
  logic                          w_wr_en, w_rd_hit;
  reg_word_e                     w_wr_word, w_rd_word;
  logic [7:0]                    w_wbyte, w_rd_byte;
  logic [NUM_CH*8-1:0]           w_ch_rd;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rd_data;
  logic                          r_rvalid;
  logic                          w_unused;

  // Page offset wraps modulo 16, so pages below BASE_PAGE decode as misses.
  assign w_wr_diff = bus.S_AXI_AWADDR[PAGE_LSB +: 4] - BASE_PAGE;
  assign w_rd_diff = bus.S_AXI_ARADDR[PAGE_LSB +: 4] - BASE_PAGE;
  assign w_wr_en   = bus.i2c_reg_wren & bus.S_AXI_WSTRB[0] & ({1'b0, w_wr_diff} < NCH);
  assign w_rd_hit  = ({1'b0, w_rd_diff} < NCH);
  assign w_wr_word = reg_word_e'(bus.S_AXI_AWADDR[7:2]);
  assign w_rd_word = reg_word_e'(bus.S_AXI_ARADDR[7:2]);
  assign w_wbyte   = bus.S_AXI_WDATA[7:0];
  assign w_unused  = ^{bus.S_AXI_AWADDR[1:0], bus.S_AXI_ARADDR[1:0],
                       bus.S_AXI_WDATA[C_S_AXI_DATA_WIDTH-1:8], bus.S_AXI_WSTRB[C_S_AXI_DATA_WIDTH/8-1:1]};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [7:0]  r_adr, r_fdr, r_cr, r_dfsrr, w_rx_head, w_rd_val;
    logic        r_mal, r_mif, r_txovf, r_rxunf, r_rxovf, r_irq;
    logic        w_wsel, w_rsel, w_sr_wr, w_fsr_wr, w_rx_pop;
    logic        w_tx_full, w_tx_empty, w_tx_drop, w_rx_full, w_rx_empty, w_rx_drop;
    logic [LW-1:0] w_tx_lvl_unused, w_rx_lvl_unused;

    assign w_wsel   = w_wr_en && (w_wr_diff == 4'(g));
    assign w_rsel   = bus.i2c_reg_rden && w_rd_hit && (w_rd_diff == 4'(g));
    assign w_sr_wr  = w_wsel && (w_wr_word == REG_SR);
    assign w_fsr_wr = w_wsel && (w_wr_word == REG_FSR);
    assign w_rx_pop = w_rsel && (w_rd_word == REG_DR);

    i2c_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .i_clk(S_AXI_ACLK), .i_arst_n(S_AXI_ARESETN),
      .i_push(w_wsel && (w_wr_word == REG_DR)), .i_din(w_wbyte),
      .i_pop(core_tx_pop[g]), .o_dout(core_tx_data[8*g +: 8]),
      .o_full(w_tx_full), .o_empty(w_tx_empty), .o_drop(w_tx_drop), .o_level(w_tx_lvl_unused)
    );

    i2c_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .i_clk(S_AXI_ACLK), .i_arst_n(S_AXI_ARESETN),
      .i_push(core_rx_push[g]), .i_din(core_rx_data[8*g +: 8]),
      .i_pop(w_rx_pop), .o_dout(w_rx_head),
      .o_full(w_rx_full), .o_empty(w_rx_empty), .o_drop(w_rx_drop), .o_level(w_rx_lvl_unused)
    );

    // Sticky bits: a same-cycle hardware set always beats the software clear.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
        r_adr   <= '0;
        r_fdr   <= '0;
        r_cr    <= '0;
        r_dfsrr <= DFSRR_RST;
        r_mal   <= 1'b0;
        r_mif   <= 1'b0;
        r_txovf <= 1'b0;
        r_rxunf <= 1'b0;
        r_rxovf <= 1'b0;
        r_irq   <= 1'b0;
      end else begin
        if (w_wsel) begin
          case (w_wr_word)
            REG_ADR:   r_adr   <= w_wbyte;
            REG_FDR:   r_fdr   <= w_wbyte;
            REG_CR:    r_cr    <= w_wbyte;
            REG_DFSRR: r_dfsrr <= w_wbyte;
            default:   ;
          endcase
        end
        r_mif   <= core_mif_set[g] | (r_mif & ~(w_sr_wr & ~w_wbyte[SR_MIF]));
        r_mal   <= core_mal_set[g] | (r_mal & ~(w_sr_wr & ~w_wbyte[SR_MAL]));
        r_txovf <= w_tx_drop | (r_txovf & ~(w_fsr_wr & w_wbyte[FSR_TXOVF]));
        r_rxovf <= w_rx_drop | (r_rxovf & ~(w_fsr_wr & w_wbyte[FSR_RXOVF]));
        r_rxunf <= (w_rx_pop & w_rx_empty) | (r_rxunf & ~(w_fsr_wr & w_wbyte[FSR_RXUNF]));
        r_irq   <= r_cr[CR_MIEN] & r_mif;
      end
    end

    always_comb begin
      w_rd_val = '0;
      case (w_rd_word)
        REG_ADR:   w_rd_val = r_adr;
        REG_FDR:   w_rd_val = r_fdr;
        REG_CR:    w_rd_val = r_cr;
        REG_SR:    w_rd_val = sr_pack(core_status[8*g +: 8], r_mal, r_mif);
        REG_DR:    w_rd_val = w_rx_empty ? 8'h00 : w_rx_head;
        REG_DFSRR: w_rd_val = r_dfsrr;
        REG_FSR:   w_rd_val = {r_txovf, r_rxunf, r_rxovf, w_rx_full, w_tx_full, w_rx_empty, w_tx_empty, 1'b0};
        default:   w_rd_val = '0;
      endcase
    end

    assign w_ch_rd[8*g +: 8]   = w_rd_val;
    assign cfg_adr[8*g +: 8]   = r_adr;
    assign cfg_fdr[8*g +: 8]   = r_fdr;
    assign cfg_cr[8*g +: 8]    = r_cr;
    assign cfg_dfsrr[8*g +: 8] = r_dfsrr;
    assign core_tx_valid[g]    = ~w_tx_empty;
    assign irq[g]              = r_irq;
  end

  always_comb begin
    w_rd_byte = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_rd_hit && (w_rd_diff == 4'(c))) w_rd_byte = w_ch_rd[8*c +: 8];
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_rd_data <= '0;
      r_rvalid  <= 1'b0;
    end else begin
      r_rvalid <= bus.i2c_reg_rden;
      if (bus.i2c_reg_rden) r_rd_data <= {{(C_S_AXI_DATA_WIDTH-8){1'b0}}, w_rd_byte};
    end
  end

  assign bus.i2c_reg_data   = r_rd_data;
  assign bus.i2c_reg_rvalid = r_rvalid;
endmodule

// File: tb/tb_i2c_regbank_mc.sv
// Self-checking bench for i2c_regbank_mc: register table, FIFO sequences, sticky status, irq and reset.
// Reads go through a scoreboard queue that is drained when rvalid is seen.
module tb_i2c_regbank_mc;
  import i2c_regbank_mc_pkg::*;

  logic        clk;
  logic        arst_n;
  logic [31:0] cfg_adr, cfg_fdr, cfg_cr, cfg_dfsrr;
  logic [31:0] core_status, core_tx_data, core_rx_data;
  logic [3:0]  core_mif_set, core_mal_set, core_tx_valid, core_tx_pop, core_rx_push, irq;

  i2c_regbank_mc_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  i2c_regbank_mc #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(12), .NUM_CH(4), .BASE_PAGE(4'h1), .FIFO_DEPTH(8)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(arst_n), .bus(bus),
    .cfg_adr(cfg_adr), .cfg_fdr(cfg_fdr), .cfg_cr(cfg_cr), .cfg_dfsrr(cfg_dfsrr),
    .core_status(core_status), .core_mif_set(core_mif_set), .core_mal_set(core_mal_set),
    .core_tx_data(core_tx_data), .core_tx_valid(core_tx_valid), .core_tx_pop(core_tx_pop),
    .core_rx_data(core_rx_data), .core_rx_push(core_rx_push), .irq(irq)
  );

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  typedef struct {
    bit         wr;
    logic [3:0] page;
    logic [5:0] word;
    logic [7:0] dat;
    bit         strb;
    string      name;
  } vec_t;

  sb_t  sbq[$];
  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard drain: every rvalid must match the oldest outstanding read.
  always @(negedge clk) begin
    if (bus.i2c_reg_rvalid) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_rvalid: got rvalid with data 0x%0h, expected no read pending", bus.i2c_reg_data);
      end else begin
        sb_t e;
        e = sbq.pop_front();
        check(e.name, bus.i2c_reg_data, e.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] ad(input logic [3:0] page, input logic [5:0] word);
    return {page, word, 2'b00};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] page, input logic [5:0] word, input logic [7:0] dat, input bit strb = 1'b1);
    bus.S_AXI_AWADDR = ad(page, word);
    bus.S_AXI_WDATA  = {24'hABCDEF, dat};
    bus.S_AXI_WSTRB  = {3'b111, strb};
    bus.i2c_reg_wren = 1'b1;
    cyc();
    bus.i2c_reg_wren = 1'b0;
    bus.S_AXI_WSTRB  = '0;
  endtask

  task automatic rd(input logic [3:0] page, input logic [5:0] word, input logic [7:0] exp, input string name);
    bus.S_AXI_ARADDR = ad(page, word);
    bus.i2c_reg_rden = 1'b1;
    sbq.push_back('{name, {24'h0, exp}});
    cyc();
    bus.i2c_reg_rden = 1'b0;
  endtask

  initial begin
    bus.S_AXI_AWADDR = '0; bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_ARADDR = '0;
    bus.i2c_reg_wren = 1'b0; bus.i2c_reg_rden = 1'b0;
    core_status = {4{8'h81}}; core_mif_set = '0; core_mal_set = '0;
    core_tx_pop = '0; core_rx_data = '0; core_rx_push = '0;
    arst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 arst_n = 1'b1;

    check("rst_irq", {28'h0, irq}, 32'h0);
    check("rst_rvalid", {31'h0, bus.i2c_reg_rvalid}, 32'h0);
    check("rst_rdata", bus.i2c_reg_data, 32'h0);
    check("rst_cfg_dfsrr", cfg_dfsrr, 32'h10101010);
    check("rst_tx_valid", {28'h0, core_tx_valid}, 32'h0);
    for (int ch = 0; ch < 4; ch++) begin
      rd(4'(ch + 1), REG_ADR,   8'h00, $sformatf("rst_adr_ch%0d", ch));
      rd(4'(ch + 1), REG_SR,    8'h81, $sformatf("rst_sr_ch%0d", ch));
      rd(4'(ch + 1), REG_DFSRR, 8'h10, $sformatf("rst_dfsrr_ch%0d", ch));
      rd(4'(ch + 1), REG_FSR,   8'h06, $sformatf("rst_fsr_ch%0d", ch));
    end

    tbl.push_back('{1, 4'h3, REG_CR,    8'hC0, 1, "wr_cr_ch2"});
    tbl.push_back('{0, 4'h3, REG_CR,    8'hC0, 1, "rd_cr_ch2"});
    tbl.push_back('{0, 4'h1, REG_CR,    8'h00, 1, "rd_cr_ch0"});
    tbl.push_back('{0, 4'h4, REG_CR,    8'h00, 1, "rd_cr_ch3"});
    tbl.push_back('{1, 4'h2, REG_ADR,   8'h5A, 1, "wr_adr_ch1"});
    tbl.push_back('{0, 4'h2, REG_ADR,   8'h5A, 1, "rd_adr_ch1"});
    tbl.push_back('{1, 4'h2, REG_ADR,   8'hFF, 0, "wr_adr_nostrb"});
    tbl.push_back('{0, 4'h2, REG_ADR,   8'h5A, 1, "rd_adr_nostrb"});
    tbl.push_back('{1, 4'h2, REG_FDR,   8'h3F, 1, "wr_fdr_ch1"});
    tbl.push_back('{0, 4'h2, REG_FDR,   8'h3F, 1, "rd_fdr_ch1"});
    tbl.push_back('{0, 4'h2, 6'd7,      8'h00, 1, "rd_unmapped"});
    tbl.push_back('{1, 4'h5, REG_ADR,   8'h77, 1, "wr_miss_hi"});
    tbl.push_back('{0, 4'h5, REG_ADR,   8'h00, 1, "rd_miss_hi"});
    tbl.push_back('{1, 4'h0, REG_ADR,   8'h66, 1, "wr_miss_lo"});
    tbl.push_back('{0, 4'h0, REG_ADR,   8'h00, 1, "rd_miss_lo"});
    tbl.push_back('{0, 4'h1, REG_ADR,   8'h00, 1, "rd_adr_ch0"});
    tbl.push_back('{0, 4'h4, REG_ADR,   8'h00, 1, "rd_adr_ch3"});
    tbl.push_back('{1, 4'h4, REG_DFSRR, 8'h2B, 1, "wr_dfsrr_ch3"});
    tbl.push_back('{0, 4'h4, REG_DFSRR, 8'h2B, 1, "rd_dfsrr_ch3"});
    tbl.push_back('{0, 4'h3, REG_CR,    8'hC0, 1, "rd_cr_ch2_last"});
    foreach (tbl[i]) begin
      if (tbl[i].wr) wr(tbl[i].page, tbl[i].word, tbl[i].dat, tbl[i].strb);
      else           rd(tbl[i].page, tbl[i].word, tbl[i].dat, tbl[i].name);
    end
    cyc(); cyc();
    check("rdata_hold", bus.i2c_reg_data, 32'h000000C0);
    check("cfg_cr", cfg_cr, 32'h00C00000);
    check("cfg_adr", cfg_adr, 32'h00005A00);
    check("cfg_fdr", cfg_fdr, 32'h00003F00);
    check("cfg_dfsrr", cfg_dfsrr, 32'h2B101010);

    core_status[31:24] = 8'hFF;
    rd(4'h4, REG_SR, 8'hA5, "sr_core_bits");
    core_status[31:24] = 8'h81;

    // TX overflow on ch0 then drain in order.
    for (int i = 1; i <= 9; i++) wr(4'h1, REG_DR, 8'(i));
    rd(4'h1, REG_FSR, 8'h8C, "fsr_tx_ovf");
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("tx_valid_%0d", i), {31'h0, core_tx_valid[0]}, 32'h1);
      check($sformatf("tx_data_%0d", i), {24'h0, core_tx_data[7:0]}, 32'(i));
      core_tx_pop[0] = 1'b1;
      cyc();
      core_tx_pop[0] = 1'b0;
    end
    check("tx_drained", {31'h0, core_tx_valid[0]}, 32'h0);
    wr(4'h1, REG_FSR, 8'h80);
    rd(4'h1, REG_FSR, 8'h06, "fsr_txovf_clr");

    // Write into a full TX FIFO while the core pops: accepted, no overflow.
    for (int i = 0; i < 8; i++) wr(4'h1, REG_DR, 8'(8'h10 + i));
    core_tx_pop[0] = 1'b1;
    wr(4'h1, REG_DR, 8'h18);
    core_tx_pop[0] = 1'b0;
    rd(4'h1, REG_FSR, 8'h0C, "fsr_full_pushpop");
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("tx_pp_data_%0d", i), {24'h0, core_tx_data[7:0]}, 32'(8'h10 + i));
      core_tx_pop[0] = 1'b1;
      cyc();
      core_tx_pop[0] = 1'b0;
    end
    core_tx_pop[0] = 1'b1;
    cyc();
    core_tx_pop[0] = 1'b0;
    wr(4'h1, REG_DR, 8'h42);
    check("tx_after_empty_pop", {23'h0, core_tx_valid[0], core_tx_data[7:0]}, 32'h142);
    core_tx_pop[0] = 1'b1;
    cyc();
    core_tx_pop[0] = 1'b0;

    // MIF / irq on ch0.
    wr(4'h1, REG_CR, 8'hC0);
    core_mif_set[0] = 1'b1;
    cyc();
    core_mif_set[0] = 1'b0;
    check("irq_lag_set", {28'h0, irq}, 32'h0);
    cyc();
    check("irq_set", {28'h0, irq}, 32'h1);
    rd(4'h1, REG_SR, 8'h83, "sr_mif");
    core_mif_set[0] = 1'b1;
    wr(4'h1, REG_SR, 8'h00);
    core_mif_set[0] = 1'b0;
    rd(4'h1, REG_SR, 8'h83, "sr_set_wins");
    wr(4'h1, REG_SR, 8'h00);
    check("irq_lag_clr", {28'h0, irq}, 32'h1);
    cyc();
    check("irq_clr", {28'h0, irq}, 32'h0);
    rd(4'h1, REG_SR, 8'h81, "sr_mif_clr");
    core_mal_set[0] = 1'b1;
    cyc();
    core_mal_set[0] = 1'b0;
    rd(4'h1, REG_SR, 8'h91, "sr_mal");
    wr(4'h1, REG_SR, 8'h10);
    rd(4'h1, REG_SR, 8'h91, "sr_mal_w1_keep");
    wr(4'h1, REG_SR, 8'hEF);
    rd(4'h1, REG_SR, 8'h81, "sr_mal_clr");

    // RX path on ch1.
    core_rx_push[1] = 1'b1;
    core_rx_data[15:8] = 8'hA5;
    cyc();
    core_rx_data[15:8] = 8'h3C;
    cyc();
    core_rx_push[1] = 1'b0;
    rd(4'h2, REG_DR, 8'hA5, "rx_dr_0");
    rd(4'h2, REG_DR, 8'h3C, "rx_dr_1");
    rd(4'h2, REG_DR, 8'h00, "rx_dr_unf");
    rd(4'h2, REG_FSR, 8'h46, "fsr_rxunf");
    wr(4'h2, REG_FSR, 8'h40);
    rd(4'h2, REG_FSR, 8'h06, "fsr_rxunf_clr");
    core_rx_push[1] = 1'b1;
    for (int i = 0; i < 9; i++) begin
      core_rx_data[15:8] = 8'(8'h20 + i);
      cyc();
    end
    core_rx_push[1] = 1'b0;
    rd(4'h2, REG_FSR, 8'h32, "fsr_rxovf");
    rd(4'h2, REG_DR, 8'h20, "rx_ovf_head");
    wr(4'h2, REG_FSR, 8'h20);
    rd(4'h2, REG_FSR, 8'h02, "fsr_rxovf_clr");

    // Reset in the middle of activity.
    for (int i = 0; i < 5; i++) wr(4'h4, REG_DR, 8'(8'h50 + i));
    check("tx3_valid_pre", {28'h0, core_tx_valid}, 32'h8);
    core_mif_set[0] = 1'b1;
    cyc();
    core_mif_set[0] = 1'b0;
    cyc();
    check("irq_pre_rst", {28'h0, irq}, 32'h1);
    rd(4'h1, REG_CR, 8'hC0, "cr_pre_rst");
    cyc(); cyc();
    #2 arst_n = 1'b0;
    #1;
    check("mid_rst_tx_valid", {28'h0, core_tx_valid}, 32'h0);
    check("mid_rst_irq", {28'h0, irq}, 32'h0);
    check("mid_rst_rdata", bus.i2c_reg_data, 32'h0);
    check("mid_rst_cfg_cr", cfg_cr, 32'h0);
    check("mid_rst_cfg_adr", cfg_adr, 32'h0);
    check("mid_rst_cfg_fdr", cfg_fdr, 32'h0);
    check("mid_rst_cfg_dfsrr", cfg_dfsrr, 32'h10101010);
    cyc();
    arst_n = 1'b1;
    rd(4'h4, REG_FSR, 8'h06, "post_rst_fsr_ch3");
    rd(4'h2, REG_FSR, 8'h06, "post_rst_fsr_ch1");
    rd(4'h1, REG_SR,  8'h81, "post_rst_sr_ch0");
    rd(4'h1, REG_CR,  8'h00, "post_rst_cr_ch0");
    cyc(); cyc();
    check("sb_empty", 32'(sbq.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
